data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit RAM words (power of 2, 16..1024).
REQ-002 Parameter MMIO_BASE, default 32'h0000_0400, byte address of the first MMIO register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemWrite  input  1  CPU data-store strobe.
REQ-006 ALUResult  input  32  CPU byte address (word-aligned; bits [1:0] ignored).
REQ-007 WriteData  input  32  CPU store data.
REQ-008 ReadData  output  32  CPU load data, combinational from ALUResult.
REQ-009 start  output  1  one-cycle pulse that releases the CPU to run.
REQ-010 host_valid / host_ready  input / output  1 / 1  host load handshake.
REQ-011 host_data  input  32  word to preload.
REQ-012 host_last  input  1  marks the final preload word.
REQ-013 host_rd_addr / host_rd_data  input / output  word-index width / 32  host result readback.
REQ-014 host_clear  input  1  returns DONE to IDLE.
REQ-015 done  output  1  high while in DONE.

Function
REQ-016 FSM states: IDLE, LOAD, START, RUN, DONE. host_ready is 1 only in IDLE and LOAD.
- IDLE->LOAD: first host handshake.
- LOAD->START: handshake with host_last=1, or the write to word DEPTH_WORDS-1.
- START->RUN: unconditional after 1 cycle.
- RUN->DONE: CPU store to DONE register.
- DONE->IDLE: host_clear=1.
REQ-017 Host handshake: host_valid&&host_ready writes host_data to RAM[load_ptr] and increments load_ptr; load_ptr clears to 0 on IDLE entry.
REQ-018 If the handshake writes word DEPTH_WORDS-1 without host_last=1, the FSM still goes to START and sticky status bit LOAD_OVF is set; no wrap-around overwrite occurs.
REQ-019 start is 1 exactly in the START state (one cycle).
REQ-020 RAM region: byte addresses 0..4*DEPTH_WORDS-1, word index ALUResult[log2(DEPTH_WORDS)+1:2].
REQ-021 CPU stores take effect on the clock edge only in RUN; loads have zero-cycle latency (combinational).
REQ-022 MMIO map, offsets from MMIO_BASE:
- +0 STATUS (RO): {28'b0, LOAD_OVF, done, RUN, busy-load}.
- +4 DONE (WO): any store with WriteData[0]=1 in RUN -> DONE.
- +8 CYCLES (RO): RUN-cycle count.
REQ-023 Reads of unmapped addresses return 32'h0; stores to unmapped or RO addresses are ignored.
REQ-024 CYCLES clears on START, increments each RUN cycle, saturates at 32'hFFFF_FFFF, and holds in DONE.
REQ-025 host_rd_data = RAM[host_rd_addr] combinationally in IDLE and DONE, and 32'h0 otherwise.
REQ-026 In RUN, host_valid is ignored. If a host load and a CPU store were ever simultaneous, the host load wins, but the states make this exclusive.

Reset
REQ-027 Reset forces: state=IDLE, load_ptr=0, LOAD_OVF=0, CYCLES=0, start=0, done=0. RAM contents are not cleared.
REQ-028 Reset mid-LOAD or mid-RUN abandons the operation immediately; the next cycle accepts a new load.

Structure
REQ-029 Shared package dmem_pkg holds: the state enum, MMIO offset constants (STATUS, DONE, CYCLES), and STATUS bit positions.
REQ-030 One sub-module, dmem_ram: DEPTH_WORDS x 32, one sync write port, two async read ports (CPU, host).

Verification
REQ-031 Load 4 words (A0..A3, host_last on the 4th): host_ready low after the 4th handshake; start pulses once the next cycle; CPU load addr 0x8 returns A2.
REQ-032 In RUN, store 0x1234 to addr 0x10, then load 0x10: ReadData=0x1234 the cycle after the store edge. A store in IDLE to 0x10 leaves it unchanged.
REQ-033 Load DEPTH_WORDS words with host_last never set: transition to START after the last word; STATUS[3]=1; RAM[0] is not overwritten.
REQ-034 Run 10 cycles, store 1 to MMIO_BASE+4: done=1; CYCLES read 10 and stays constant; host_rd_addr=4 returns the stored word; host_clear returns to IDLE.
REQ-035 Assert reset mid-LOAD after 2 words: state IDLE, load_ptr 0, start never pulses. A new 1-word load with host_last overwrites RAM[0].
REQ-036 Load unmapped addr 0xFFFF_0000 returns 0. A store to STATUS is ignored, and STATUS still reads 0x2 in RUN.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller: FSM states,
// MMIO register offsets and STATUS bit positions.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [31:0] MMIO_STATUS = 32'h0000_0000;
    localparam logic [31:0] MMIO_DONE   = 32'h0000_0004;
    localparam logic [31:0] MMIO_CYCLES = 32'h0000_0008;

    localparam int STAT_BUSY_LOAD = 0;
    localparam int STAT_RUN       = 1;
    localparam int STAT_DONE      = 2;
    localparam int STAT_LOAD_OVF  = 3;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU data bus plus host preload/readback channel of the data memory controller.
// Host load is valid/ready; CPU and host readback paths are combinational.
interface data_mem_ctrl_if #(
    parameter int AW = 8
);
    logic          MemWrite;
    logic [31:0]   ALUResult;
    logic [31:0]   WriteData;
    logic [31:0]   ReadData;
    logic          start;
    logic          host_valid;
    logic          host_ready;
    logic [31:0]   host_data;
    logic          host_last;
    logic [AW-1:0] host_rd_addr;
    logic [31:0]   host_rd_data;
    logic          host_clear;
    logic          done;

    modport slave (
        input  MemWrite, ALUResult, WriteData,
        input  host_valid, host_data, host_last, host_rd_addr, host_clear,
        output ReadData, start, host_ready, host_rd_data, done
    );

    modport master (
        output MemWrite, ALUResult, WriteData,
        output host_valid, host_data, host_last, host_rd_addr, host_clear,
        input  ReadData, start, host_ready, host_rd_data, done
    );
endinterface

// File: rtl/dmem_ram.sv
// DEPTH_WORDS x 32 RAM: one synchronous write port, two asynchronous read ports.
// Writes land on the rising edge; reads are zero-latency; no backpressure.
module dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] cpu_addr,
    output logic [31:0]   cpu_data,
    input  logic [AW-1:0] host_addr,
    output logic [31:0]   host_data
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign cpu_data  = mem[cpu_addr];
    assign host_data = mem[host_addr];
endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: host preloads RAM, pulses start, CPU runs until it stores DONE.
// CPU loads are zero-latency; host_ready drops outside IDLE/LOAD to stall the host.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0400
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state, nxt;
    logic [AW-1:0] load_ptr;
    logic          load_ovf;
    logic [31:0]   cycles;
    logic [31:0]   status;

    logic          host_fire, last_word, cpu_run_wr;
    logic          in_ram, sel_status, sel_done, sel_cycles;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata, ram_cpu_rd, ram_host_rd;

    wire unused_addr_lsb = ^bus.ALUResult[1:0];

    assign host_fire  = bus.host_valid && (state == ST_IDLE || state == ST_LOAD);
    assign last_word  = bus.host_last || (load_ptr == AW'(DEPTH_WORDS - 1));
    assign cpu_run_wr = (state == ST_RUN) && bus.MemWrite;

    assign in_ram     = (bus.ALUResult[31:AW+2] == '0);
    assign sel_status = ({bus.ALUResult[31:2], 2'b00} == MMIO_BASE + MMIO_STATUS);
    assign sel_done   = ({bus.ALUResult[31:2], 2'b00} == MMIO_BASE + MMIO_DONE);
    assign sel_cycles = ({bus.ALUResult[31:2], 2'b00} == MMIO_BASE + MMIO_CYCLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (host_fire) nxt = last_word ? ST_START : ST_LOAD;
            ST_LOAD:  if (host_fire && last_word) nxt = ST_START;
            ST_START: nxt = ST_RUN;
            ST_RUN:   if (cpu_run_wr && sel_done && bus.WriteData[0]) nxt = ST_DONE;
            ST_DONE:  if (bus.host_clear) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // Host preload owns the write port; the CPU only writes in RUN, so they never collide.
    always_comb begin
        bus.host_ready = (state == ST_IDLE) || (state == ST_LOAD);
        bus.start      = (state == ST_START);
        bus.done       = (state == ST_DONE);
        ram_we         = 1'b0;
        ram_waddr      = load_ptr;
        ram_wdata      = bus.host_data;
        if (host_fire) begin
            ram_we = 1'b1;
        end else if (cpu_run_wr && in_ram) begin
            ram_we    = 1'b1;
            ram_waddr = bus.ALUResult[AW+1:2];
            ram_wdata = bus.WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_ptr <= '0;
            load_ovf <= 1'b0;
            cycles   <= '0;
        end else begin
            if (host_fire) begin
                load_ptr <= load_ptr + AW'(1);
                if (load_ptr == AW'(DEPTH_WORDS - 1) && !bus.host_last) load_ovf <= 1'b1;
            end else if (state == ST_DONE && nxt == ST_IDLE) begin
                load_ptr <= '0;
            end
            if (state == ST_START)    cycles <= '0;
            else if (state == ST_RUN) cycles <= sat_inc(cycles);
        end
    end

    always_comb begin
        status                 = '0;
        status[STAT_BUSY_LOAD] = (state == ST_LOAD);
        status[STAT_RUN]       = (state == ST_RUN);
        status[STAT_DONE]      = (state == ST_DONE);
        status[STAT_LOAD_OVF]  = load_ovf;
    end

    always_comb begin
        bus.ReadData = 32'h0;
        if (in_ram)          bus.ReadData = ram_cpu_rd;
        else if (sel_status) bus.ReadData = status;
        else if (sel_cycles) bus.ReadData = cycles;
    end

    assign bus.host_rd_data = (state == ST_IDLE || state == ST_DONE) ? ram_host_rd : 32'h0;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk       (clk),
        .we        (ram_we),
        .waddr     (ram_waddr),
        .wdata     (ram_wdata),
        .cpu_addr  (bus.ALUResult[AW+1:2]),
        .cpu_data  (ram_cpu_rd),
        .host_addr (bus.host_rd_addr),
        .host_data (ram_host_rd)
    );
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: table of RUN-phase CPU vectors plus
// hand-written sequences for overflow load, DONE/clear and mid-load reset.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.AW(8)) bus ();

    data_mem_ctrl #(
        .DEPTH_WORDS (256),
        .MMIO_BASE   (32'h0000_0400)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.MemWrite  = 1'b0;
        bus.ALUResult = addr;
        #1;
        check(name, bus.ReadData, exp);
    endtask

    task automatic host_word(input logic [31:0] d, input logic last);
        bus.host_valid = 1'b1;
        bus.host_data  = d;
        bus.host_last  = last;
        tick();
        bus.host_valid = 1'b0;
        bus.host_last  = 1'b0;
    endtask

    task automatic finish_run();
        bus.MemWrite  = 1'b1;
        bus.ALUResult = 32'h0000_0404;
        bus.WriteData = 32'h1;
        tick();
        bus.MemWrite  = 1'b0;
    endtask

    initial begin
        int starts;

        reset            = 1'b1;
        bus.MemWrite     = 1'b0;
        bus.ALUResult    = '0;
        bus.WriteData    = '0;
        bus.host_valid   = 1'b0;
        bus.host_data    = '0;
        bus.host_last    = 1'b0;
        bus.host_rd_addr = '0;
        bus.host_clear   = 1'b0;

        vt[0] = '{1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'hA000_0002};
        vt[1] = '{1'b0, 32'h0000_000C, 32'h0,         1'b1, 32'hA000_0003};
        vt[2] = '{1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 32'h0};
        vt[3] = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h2};
        vt[4] = '{1'b1, 32'h0000_0400, 32'hFF,        1'b1, 32'h2};
        vt[5] = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h2};
        vt[6] = '{1'b1, 32'h0000_0010, 32'h0000_1234, 1'b0, 32'h0};
        vt[7] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_1234};
        vt[8] = '{1'b0, 32'h0000_0408, 32'h0,         1'b1, 32'd8};
        vt[9] = '{1'b1, 32'h0000_0404, 32'h1,         1'b1, 32'h0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_host_ready", 32'(bus.host_ready), 32'h1);
        check("rst_start", 32'(bus.start), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        rd_chk("rst_status", 32'h0000_0400, 32'h0);
        rd_chk("rst_cycles", 32'h0000_0408, 32'h0);
        reset = 1'b0;
        tick();

        // 4-word load, last word flagged
        host_word(32'hA000_0000, 1'b0);
        host_word(32'hA000_0001, 1'b0);
        host_word(32'hA000_0002, 1'b0);
        bus.host_valid = 1'b1;
        bus.host_data  = 32'hA000_0003;
        bus.host_last  = 1'b1;
        #1;
        check("load4_start_before_last", 32'(bus.start), 32'h0);
        tick();
        bus.host_valid = 1'b0;
        bus.host_last  = 1'b0;
        #1;
        check("load4_ready_low", 32'(bus.host_ready), 32'h0);
        check("load4_start_pulse", 32'(bus.start), 32'h1);
        rd_chk("start_status", 32'h0000_0400, 32'h0);
        tick();
        check("load4_start_one_cycle", 32'(bus.start), 32'h0);

        // RUN-phase vectors, host pushing data that must be ignored
        for (int i = 0; i < 10; i++) begin
            bus.MemWrite     = vt[i].we;
            bus.ALUResult    = vt[i].addr;
            bus.WriteData    = vt[i].wdata;
            bus.host_valid   = 1'b1;
            bus.host_data    = 32'hDEAD_BEEF;
            bus.host_rd_addr = 8'd0;
            #1;
            if (vt[i].chk) check($sformatf("run_vec%0d", i), bus.ReadData, vt[i].exp);
            check($sformatf("run_hostrd%0d", i), bus.host_rd_data, 32'h0);
            tick();
        end
        bus.MemWrite   = 1'b0;
        bus.host_valid = 1'b0;

        // DONE: cycle count frozen, results visible to host
        #1;
        check("done_flag", 32'(bus.done), 32'h1);
        rd_chk("done_cycles", 32'h0000_0408, 32'd10);
        rd_chk("done_status", 32'h0000_0400, 32'h4);
        bus.host_rd_addr = 8'd4;
        #1;
        check("done_hostrd4", bus.host_rd_data, 32'h0000_1234);
        tick();
        tick();
        rd_chk("done_cycles_hold", 32'h0000_0408, 32'd10);
        bus.host_rd_addr = 8'd0;
        #1;
        check("host_ignored_in_run", bus.host_rd_data, 32'hA000_0000);
        check("done_ready_low", 32'(bus.host_ready), 32'h0);
        bus.host_clear = 1'b1;
        tick();
        bus.host_clear = 1'b0;
        #1;
        check("clear_done_low", 32'(bus.done), 32'h0);
        check("clear_ready", 32'(bus.host_ready), 32'h1);

        // CPU store outside RUN is dropped
        bus.MemWrite  = 1'b1;
        bus.ALUResult = 32'h0000_0010;
        bus.WriteData = 32'h0000_0BAD;
        tick();
        bus.MemWrite     = 1'b0;
        bus.host_rd_addr = 8'd4;
        #1;
        check("idle_store_hostrd", bus.host_rd_data, 32'h0000_1234);
        rd_chk("idle_store_cpurd", 32'h0000_0010, 32'h0000_1234);
        check("idle_store_state", 32'(bus.host_ready), 32'h1);

        // Full-depth load without host_last
        for (int i = 0; i < 256; i++) begin
            bus.host_valid = 1'b1;
            bus.host_data  = 32'h5000_0000 + 32'(i);
            bus.host_last  = 1'b0;
            if (i == 255) begin
                #1;
                check("ovf_start_before_last", 32'(bus.start), 32'h0);
                check("ovf_ready_before_last", 32'(bus.host_ready), 32'h1);
            end
            tick();
        end
        bus.host_data = 32'hFFFF_FFFF;
        #1;
        check("ovf_start_pulse", 32'(bus.start), 32'h1);
        rd_chk("ovf_status_start", 32'h0000_0400, 32'h8);
        tick();
        bus.host_valid = 1'b0;
        check("ovf_start_one_cycle", 32'(bus.start), 32'h0);
        rd_chk("ovf_status_run", 32'h0000_0400, 32'hA);
        rd_chk("ovf_ram0_kept", 32'h0000_0000, 32'h5000_0000);
        rd_chk("ovf_ram_last", 32'h0000_03FC, 32'h5000_00FF);
        finish_run();
        #1;
        check("ovf_done", 32'(bus.done), 32'h1);
        rd_chk("ovf_status_done", 32'h0000_0400, 32'hC);
        bus.host_clear = 1'b1;
        tick();
        bus.host_clear = 1'b0;

        // Reset in the middle of a load
        host_word(32'hC000_0000, 1'b0);
        host_word(32'hC000_0001, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_mid_ready", 32'(bus.host_ready), 32'h1);
        check("rst_mid_done", 32'(bus.done), 32'h0);
        rd_chk("rst_mid_status", 32'h0000_0400, 32'h0);
        tick();
        reset  = 1'b0;
        starts = 0;
        repeat (3) begin
            if (bus.start) starts++;
            tick();
        end
        check("rst_mid_no_start", 32'(starts), 32'h0);
        host_word(32'hD000_0000, 1'b1);
        #1;
        check("reload_start", 32'(bus.start), 32'h1);
        tick();
        rd_chk("reload_ram0", 32'h0000_0000, 32'hD000_0000);
        rd_chk("reload_ram1_old", 32'h0000_0004, 32'hC000_0001);
        rd_chk("reload_status_run", 32'h0000_0400, 32'h2);
        finish_run();
        #1;
        check("reload_done", 32'(bus.done), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
